reg_hazard_ctrl: RTL
====================

# reg_hazard_ctrl

Register-file hazard controller for the five-stage SampleCPU pipeline. Keeps a shadow pipeline of in-flight destination tags for the EX, MEM and WB stages. Each cycle it selects the forwarding source for both ID read ports, and it interlocks ID for load-use hazards and for the multi-cycle divider. It sits beside `regfile` in ID and replaces ad-hoc EX-only bypass logic with one ordered EX > MEM > WB priority.

## Interface
- `DIV_CYCLES`, default 33: EX occupancy of a divide, in cycles; must be ≥ 2.
- `CNT_W`, default 6: divide counter width; must satisfy `2**CNT_W > DIV_CYCLES`.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  external freeze (SRAM wait); holds all internal state.
- `flush`  in  1  exception flush; kills every in-flight tag.
- `id_valid`  in  1  ID holds a real instruction.
- `id_re1`, `id_re2`  in  1 each  read-port enables.
- `id_raddr1`, `id_raddr2`  in  5 each  read-port addresses.
- `id_we`  in  1  instruction writes a GPR.
- `id_waddr`  in  5  destination GPR.
- `id_is_load`  in  1  instruction is a load.
- `id_is_div`  in  1  instruction is DIV/DIVU.
- `fwd_sel1`, `fwd_sel2`  out  2 each  source select per read port: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
- `stall_id`  out  1  hold PC/IF/ID this cycle.
- `ex_bubble`  out  1  inject NOP into EX next edge.
- `div_busy`  out  1  divider occupying EX.

## Operation
- Tag entry format: {valid, we, waddr[4:0], is_load}. There are three registered entries: `t_ex`, `t_mem`, `t_wb`.
- Advance happens when `stall_in`=0 and `div_busy`=0:
  - `t_wb` ← `t_mem`; `t_mem` ← `t_ex`.
  - `t_ex` ← ID tag if `id_valid` and not `stall_id`; otherwise an invalid tag (bubble).
- Freeze: if `stall_in`=1, all tags and the counter hold.
- Divide: when a div tag enters `t_ex`, the counter loads `DIV_CYCLES-1`. While the counter ≠ 0, `div_busy`=1, `t_ex` holds, and `t_mem` ← invalid. When the counter reaches 0, normal advance resumes.
- Forwarding for port *k* (combinational):
  - 0 if `id_re`*k*=0 or `raddr`*k*=0.
  - Otherwise the first of EX (1), MEM (2), WB (3) whose entry has `valid & we & waddr==raddr`*k*.
  - Otherwise 0.
- Load-use hazard: `t_ex` is a valid load whose `waddr` matches an enabled, nonzero `raddr`. Forwarding from a load in MEM is legal.
- `stall_id` = `id_valid & (load_use | div_busy | div_issue_conflict)`.
  - `div_issue_conflict`: `t_ex` holds a div this cycle with the counter not yet loaded. It only arises on the first cycle of a divide; treat it as part of `div_busy`.
- `ex_bubble` = `stall_id & ~stall_in & ~div_busy`.
- Flush: next edge clears all three valid bits and the counter, regardless of `stall_in`. Flush has priority over every other event.
- Writes to GPR 0 are tagged but never match, because `raddr`=0 is filtered first.

## Timing
- Reset: all tag valid bits 0, counter 0. Outputs: `fwd_sel*`=0, `stall_id`=0, `ex_bubble`=0, `div_busy`=0.
- `fwd_sel*`, `stall_id` and `ex_bubble` are combinational from the registered tags plus the ID inputs, and are valid in the same cycle. `div_busy` is registered.
- Load-use costs exactly 1 stall cycle. On the following cycle the load is in MEM and `fwd_sel`=2.
- A divide holds `stall_id`=1 for `DIV_CYCLES` consecutive cycles (with `stall_in` low).
- `stall_in` during a load-use stall extends the stall; no second bubble is inserted.
- Reset asserted mid-divide: the counter clears asynchronously and `div_busy` drops at once.

## Structure
- Shared package `hazard_pkg.vh`: tag-field widths, bit offsets, and the `FWD_RF`/`FWD_EX`/`FWD_MEM`/`FWD_WB` encodings. These encodings are reused by the ID bypass mux.
- One sub-module, `fwd_select`: a pure combinational priority matcher, instantiated once per read port.
- The counter and tag registers live in the top module.

## Test plan
- Back-to-back ALU: `addu $3` then `addu $4,$3,$3` → `fwd_sel1`=`fwd_sel2`=1, no stall.
- Load-use: `lw $5`, then `addu $6,$5,$0` → `stall_id`=1 for 1 cycle and `ex_bubble`=1; next cycle `fwd_sel1`=2.
- Priority: writes to `$7` in EX, MEM and WB at once, then a read of `$7` → `fwd_sel`=1. A read of `$0` with a `$0` write in EX → `fwd_sel`=0.
- Divide with `DIV_CYCLES`=33: a dependent instruction in ID sees `stall_id` high for 33 cycles, then `fwd_sel`=1.
- Flush asserted in cycle 5 of a divide with `stall_in`=1 → next edge: `div_busy`=0, all `fwd_sel`=0.
- `resetn` pulled low mid-divide → `div_busy` and `stall_id` go low immediately. After release, a load-use pair again stalls exactly 1 cycle.

Source files
------------

// File: rtl/reg_hazard_ctrl_pkg.sv
// Shared definitions for the register hazard controller: tag layout and the
// forwarding-source encodings also consumed by the ID bypass mux.
package reg_hazard_ctrl_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned FWD_W  = 2;

   // In-flight destination tag, MSB first: {valid, we, waddr, is_load}
   typedef struct packed {
      logic              valid;
      logic              we;
      logic [REG_AW-1:0] waddr;
      logic              is_load;
   } tag_t;

   localparam int unsigned TAG_W         = $bits(tag_t);
   localparam int unsigned TAG_LOAD_BIT  = 0;
   localparam int unsigned TAG_WADDR_LSB = 1;
   localparam int unsigned TAG_WE_BIT    = TAG_WADDR_LSB + REG_AW;
   localparam int unsigned TAG_VALID_BIT = TAG_WE_BIT + 1;

   localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
   localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
   localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
   localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

   localparam tag_t TAG_NONE = '0;

   // A stage can supply a value only if it holds a live GPR write to raddr
   function automatic logic tag_hit(input tag_t t, input logic [REG_AW-1:0] raddr);
      return t.valid & t.we & (t.waddr == raddr);
   endfunction

endpackage

// File: rtl/reg_hazard_ctrl_fwd_select.sv
// Priority matcher for one ID read port: picks the youngest in-flight writer
// (EX > MEM > WB) and flags a load still sitting in EX.
module fwd_select
   import reg_hazard_ctrl_pkg::*;
(
   input  logic              re,
   input  logic [4:0]        raddr,
   input  logic [TAG_W-1:0]  t_ex,
   input  logic [TAG_W-1:0]  t_mem,
   input  logic [TAG_W-1:0]  t_wb,
   output logic [FWD_W-1:0]  sel_c,
   output logic              ld_hit_c
);

   tag_t ex_tag;
   tag_t mem_tag;
   tag_t wb_tag;
   logic port_en;

   assign ex_tag  = tag_t'(t_ex);
   assign mem_tag = tag_t'(t_mem);
   assign wb_tag  = tag_t'(t_wb);

   // GPR 0 is never forwarded, so $0 writes in flight can never match
   assign port_en = re & (raddr != '0);

   always_comb begin
      sel_c    = FWD_RF;
      ld_hit_c = 1'b0;
      if (port_en) begin
         if (tag_hit(ex_tag, raddr)) begin
            sel_c = FWD_EX;
         end else if (tag_hit(mem_tag, raddr)) begin
            sel_c = FWD_MEM;
         end else if (tag_hit(wb_tag, raddr)) begin
            sel_c = FWD_WB;
         end
         ld_hit_c = ex_tag.valid & ex_tag.is_load & (ex_tag.waddr == raddr);
      end
   end

endmodule

// File: rtl/reg_hazard_ctrl.sv
// Register-file hazard controller: shadow EX/MEM/WB destination tags,
// per-port forwarding select, load-use and divider interlocks.
module reg_hazard_ctrl
   import reg_hazard_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 33,
   parameter int unsigned CNT_W      = 6
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall_in,
   input  logic        flush,
   input  logic        id_valid,
   input  logic        id_re1,
   input  logic        id_re2,
   input  logic [4:0]  id_raddr1,
   input  logic [4:0]  id_raddr2,
   input  logic        id_we,
   input  logic [4:0]  id_waddr,
   input  logic        id_is_load,
   input  logic        id_is_div,
   output logic [1:0]  fwd_sel1,
   output logic [1:0]  fwd_sel2,
   output logic        stall_id,
   output logic        ex_bubble,
   output logic        div_busy
);

   tag_t             t_ex, t_mem, t_wb;
   tag_t             t_ex_nxt, t_mem_nxt, t_wb_nxt;
   tag_t             id_tag;
   logic [CNT_W-1:0] div_cnt, div_cnt_nxt;
   logic             ex_div_pend, ex_div_pend_nxt;
   logic             div_busy_nxt;
   logic             ld_hit1, ld_hit2;
   logic             load_use, div_hold, issue;

   fwd_select u_fwd1 (
      .re       (id_re1),
      .raddr    (id_raddr1),
      .t_ex     (t_ex),
      .t_mem    (t_mem),
      .t_wb     (t_wb),
      .sel_c    (fwd_sel1),
      .ld_hit_c (ld_hit1)
   );

   fwd_select u_fwd2 (
      .re       (id_re2),
      .raddr    (id_raddr2),
      .t_ex     (t_ex),
      .t_mem    (t_mem),
      .t_wb     (t_wb),
      .sel_c    (fwd_sel2),
      .ld_hit_c (ld_hit2)
   );

   // Interlocks and next-state of the tag pipe and divide counter
   always_comb begin
      id_tag          = '{valid: 1'b1, we: id_we, waddr: id_waddr, is_load: id_is_load};
      t_ex_nxt        = t_ex;
      t_mem_nxt       = t_mem;
      t_wb_nxt        = t_wb;
      div_cnt_nxt     = div_cnt;
      ex_div_pend_nxt = ex_div_pend;

      // A divide that just entered EX blocks exactly like a running one
      div_hold  = div_busy | ex_div_pend;
      load_use  = ld_hit1 | ld_hit2;
      stall_id  = id_valid & (load_use | div_hold);
      ex_bubble = stall_id & ~stall_in & ~div_hold;
      issue     = id_valid & ~stall_id;

      if (flush) begin
         t_ex_nxt        = TAG_NONE;
         t_mem_nxt       = TAG_NONE;
         t_wb_nxt        = TAG_NONE;
         div_cnt_nxt     = '0;
         ex_div_pend_nxt = 1'b0;
      end else if (!stall_in) begin
         if (ex_div_pend) begin
            div_cnt_nxt     = CNT_W'(DIV_CYCLES - 1);
            ex_div_pend_nxt = 1'b0;
            t_mem_nxt       = TAG_NONE;
            t_wb_nxt        = t_mem;
         end else if (div_busy) begin
            div_cnt_nxt = div_cnt - CNT_W'(1);
            t_mem_nxt   = TAG_NONE;
            t_wb_nxt    = t_mem;
         end else begin
            t_wb_nxt        = t_mem;
            t_mem_nxt       = t_ex;
            t_ex_nxt        = issue ? id_tag : TAG_NONE;
            ex_div_pend_nxt = issue & id_is_div;
         end
      end

      div_busy_nxt = (div_cnt_nxt != '0);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         t_ex        <= TAG_NONE;
         t_mem       <= TAG_NONE;
         t_wb        <= TAG_NONE;
         div_cnt     <= '0;
         ex_div_pend <= 1'b0;
         div_busy    <= 1'b0;
      end else begin
         t_ex        <= t_ex_nxt;
         t_mem       <= t_mem_nxt;
         t_wb        <= t_wb_nxt;
         div_cnt     <= div_cnt_nxt;
         ex_div_pend <= ex_div_pend_nxt;
         div_busy    <= div_busy_nxt;
      end
   end

endmodule
